// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor.
// The operand is split into GROUP-bit lookahead groups and one group is resolved
// per pipeline stage; the group carry is registered between stages.
// Upper operand groups wait in skew registers until their stage comes up.
// Streaming valid/ready interface: the whole pipe advances together or holds.
// Optional feature macro: CLA_PIPE_SAT_EN (clamp out_sum to the signed limit on overflow).
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int STAGES = WIDTH / GROUP;

  generate
    if ((WIDTH % GROUP) != 0 || GROUP < 1) begin : g_bad_cfg
      $error("cla_pipe_adder: WIDTH must be a positive multiple of GROUP");
    end
  endgenerate

  // Group lookahead: every carry is a flat sum of products of g/p and the group
  // carry-in, so no carry ripples through the group.
  function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] p,
                                                 input logic [GROUP-1:0] g,
                                                 input logic             c0);
    logic [GROUP:0] c;
    logic           pr;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = g[i];
      pr     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pr & g[j]);
        pr     = pr & p[j];
      end
      c[i+1] = c[i+1] | (pr & c0);
    end
    return c;
  endfunction

`ifdef CLA_PIPE_SAT_EN
  // On overflow the wrapped MSB is the inverse of the true sign, so a wrapped
  // negative value means the true result was above the positive limit.
  function automatic logic [WIDTH-1:0] sat_clamp(input logic [WIDTH-1:0] s,
                                                 input logic             ovf);
    logic [WIDTH-1:0] lim;
    lim = s[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    return ovf ? lim : s;
  endfunction
`endif

  logic             adv;

  logic             vld_p [STAGES];
  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic             c_p   [STAGES];
  logic [WIDTH-1:0] s_p   [STAGES];

  logic [GROUP-1:0] gp     [STAGES];
  logic [GROUP-1:0] gg     [STAGES];
  logic [GROUP:0]   gc     [STAGES];
  logic [GROUP-1:0] gs     [STAGES];
  logic [WIDTH-1:0] s_next [STAGES];

  logic [WIDTH-1:0] fin_sum;
  logic             fin_cout;
  logic             fin_ovf;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // Per-stage group resolution: stage k works on group k of the skewed operands.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      gp[k]     = a_p[k][k*GROUP +: GROUP] ^ b_p[k][k*GROUP +: GROUP];
      gg[k]     = a_p[k][k*GROUP +: GROUP] & b_p[k][k*GROUP +: GROUP];
      gc[k]     = cla_carries(gp[k], gg[k], c_p[k]);
      gs[k]     = gp[k] ^ gc[k][GROUP-1:0];
      s_next[k] = s_p[k];
      s_next[k][k*GROUP +: GROUP] = gs[k];
    end
  end

  assign fin_cout = gc[STAGES-1][GROUP];
  assign fin_ovf  = gc[STAGES-1][GROUP] ^ gc[STAGES-1][GROUP-1];
`ifdef CLA_PIPE_SAT_EN
  assign fin_sum  = sat_clamp(s_next[STAGES-1], fin_ovf);
`else
  assign fin_sum  = s_next[STAGES-1];
`endif

  // Valid chain: bubbles advance like real slots, everything holds when !adv.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) vld_p[k] <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      vld_p[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) vld_p[k] <= vld_p[k-1];
      out_valid <= vld_p[STAGES-1];
    end
  end

  // Datapath: capture operands (B inverted for subtract), then shift partial
  // sums, skewed operands and the group carry one stage per advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_p[k] <= '0;
        b_p[k] <= '0;
        c_p[k] <= 1'b0;
        s_p[k] <= '0;
      end
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (adv) begin
      // stage 0: operand capture
      a_p[0] <= in_a;
      b_p[0] <= sub ? ~in_b : in_b;
      c_p[0] <= sub | cin;
      s_p[0] <= '0;
      // stages 1..STAGES-1: group carry crosses the boundary here
      for (int k = 1; k < STAGES; k++) begin
        a_p[k] <= a_p[k-1];
        b_p[k] <= b_p[k-1];
        c_p[k] <= gc[k-1][GROUP];
        s_p[k] <= s_next[k-1];
      end
      // output stage
      out_sum  <= fin_sum;
      out_cout <= fin_cout;
      out_ovf  <= fin_ovf;
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder (WIDTH=16, GROUP=4): directed cases, reset behaviour,
// random back-pressure stream and back-to-back throughput against a reference model.
module tb_cla_pipe_adder;

  localparam int W      = 16;
  localparam int STAGES = 4;
`ifdef CLA_PIPE_SAT_EN
  localparam logic [15:0] OVF_SUM = 16'h7FFF;
`else
  localparam logic [15:0] OVF_SUM = 16'h8000;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;

  cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_emit = 0;
  int          n_acc = 0;
  int          first_emit_cyc = -1;
  int          first_lat = -1;
  int          last_emit_cyc = 0;
  int          last_lat = 0;
  logic [15:0] last_sum = '0;
  logic        last_cout = 1'b0;
  logic        last_ovf = 1'b0;
  logic        held = 1'b0;
  logic [15:0] h_sum;
  logic        h_cout;
  logic        h_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic, result taken modulo 2^16.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic s);
    exp_t e;
    int   sa, sb, t, ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = int'(a);
    ub = int'(b);
    if (s) begin
      t      = sa - sb;
      e.cout = (ua >= ub);
    end else begin
      t      = sa + sb + int'(c);
      e.cout = (ua + ub + int'(c)) > 65535;
    end
    e.ovf = (t > 32767) || (t < -32768);
    e.sum = t[15:0];
`ifdef CLA_PIPE_SAT_EN
    if (e.ovf) e.sum = (t > 0) ? 16'h7FFF : 16'h8000;
`endif
    e.acc = 0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop on emission, push on accept, watch the held-output rules.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      held = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        n_emit++;
        last_emit_cyc = cyc;
        if (q.size() == 0) begin
          check("spurious_emit", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("sum", 32'(out_sum), 32'(e.sum));
          check("cout", 32'(out_cout), 32'(e.cout));
          check("ovf", 32'(out_ovf), 32'(e.ovf));
          last_sum  = out_sum;
          last_cout = out_cout;
          last_ovf  = out_ovf;
          last_lat  = cyc - (e.acc + 1);
          if (first_emit_cyc < 0) begin
            first_emit_cyc = cyc;
            first_lat      = last_lat;
          end
        end
      end
      if (out_valid && !out_ready) begin
        check("in_ready_when_held", 32'(in_ready), 32'd0);
        if (held) begin
          check("held_sum", 32'(out_sum), 32'(h_sum));
          check("held_cout", 32'(out_cout), 32'(h_cout));
          check("held_ovf", 32'(out_ovf), 32'(h_ovf));
        end
        held   = 1'b1;
        h_sum  = out_sum;
        h_cout = out_cout;
        h_ovf  = out_ovf;
      end else begin
        held = 1'b0;
      end
      if (in_valid && in_ready) begin
        e     = model(in_a, in_b, cin, sub);
        e.acc = cyc;
        q.push_back(e);
        n_acc++;
      end
    end
  end

  task automatic wait_drain(input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic dir_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s, input logic [15:0] es,
                        input logic ec, input logic eo);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a = a; in_b = b; cin = c; sub = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain(20);
    check({tag, "_sum"}, 32'(last_sum), 32'(es));
    check({tag, "_cout"}, 32'(last_cout), 32'(ec));
    check({tag, "_ovf"}, 32'(last_ovf), 32'(eo));
    check({tag, "_lat"}, 32'(last_lat), 32'(STAGES));
  endtask

  task automatic rand_op();
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    cin  = 1'($urandom);
    sub  = 1'($urandom);
  endtask

  initial begin
    int emit0, acc0, loaded, accepted, guard;
    logic acc;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; cin = 1'b0; sub = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(out_sum), 32'd0);
    check("rst_cout", 32'(out_cout), 32'd0);
    check("rst_ovf", 32'(out_ovf), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // directed cases
    dir_op("add", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    dir_op("chain", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    dir_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    dir_op("sub", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    dir_op("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, OVF_SUM, 1'b0, 1'b1);
    dir_op("subovf", 16'h8000, 16'h0001, 1'b0, 1'b1, (OVF_SUM == 16'h8000) ? 16'h7FFF : 16'h8000, 1'b1, 1'b1);

    // mid-operation reset with three results in flight
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      rand_op();
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    emit0 = n_emit;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_emit", 32'(n_emit - emit0), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);

    // back-pressure stream: 8 random ops, bubbles, out_ready toggling
    emit0 = n_emit; acc0 = n_acc;
    loaded = 0; accepted = 0; guard = 0; acc = 1'b0;
    while (accepted < 8 && guard < 500) begin
      @(posedge clk);
      #1;
      if (acc || !in_valid) begin
        if (loaded < 8 && $urandom_range(0, 3) != 0) begin
          rand_op();
          in_valid = 1'b1;
          loaded++;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = 1'($urandom);
      @(negedge clk);
      #1;
      acc = in_valid && in_ready;
      if (acc) accepted++;
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      guard++;
    end
    out_ready = 1'b1;
    wait_drain(20);
    check("bp_accepted", 32'(n_acc - acc0), 32'd8);
    check("bp_emitted", 32'(n_emit - emit0), 32'd8);

    // throughput: 100 back-to-back ops with out_ready held high
    emit0 = n_emit; acc0 = n_acc; first_emit_cyc = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      rand_op();
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain(50);
    check("tput_accepted", 32'(n_acc - acc0), 32'd100);
    check("tput_emitted", 32'(n_emit - emit0), 32'd100);
    check("tput_span", 32'(last_emit_cyc - first_emit_cyc), 32'd99);
    check("tput_first_lat", 32'(first_lat), 32'(STAGES));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    n_chk++;
    n_err++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
